dcache_write_buffer: RTL
========================

// Module: dcache_write_buffer
// PURPOSE
//  Line-granular posted write buffer between the L1 data cache controller and Data_Memory.
//  Accepts dirty-line write-backs from the cache with a 1-cycle ack, then drains them to memory in the background.
//  Cache read requests are served either by forwarding from the buffer or by a memory fetch.
//  The cache side and the memory side both use the enable/write/ack line protocol.
// PARAMETERS
//  DEPTH   2    buffered lines; power of 2, >= 2
//  ADDR_W  32   byte-address width
//  LINE_W  256  cache line width in bits (32 B)
// PORTS
//  clk_i         in   1       clock; all state updates on rising edge
//  rst_i         in   1       reset; asynchronous, active-high
//  cache_addr_i  in   ADDR_W  cache request byte address; bits [4:0] ignored
//  cache_data_i  in   LINE_W  write-back line data
//  cache_enable_i in  1       request valid; held stable until cache_ack_o
//  cache_write_i in   1       1 = write-back, 0 = line fill
//  cache_ack_o   out  1       1-cycle completion pulse to cache
//  cache_data_o  out  LINE_W  fill data; valid only in the cache_ack_o cycle
//  mem_addr_o    out  ADDR_W  memory request address, line-aligned ([4:0] = 0)
//  mem_data_o    out  LINE_W  memory write data
//  mem_enable_o  out  1       memory request; held until mem_ack_i
//  mem_write_o   out  1       memory write strobe
//  mem_ack_i     in   1       memory completion pulse
//  mem_data_i    in   LINE_W  memory read data; valid with mem_ack_i
//  empty_o       out  1       1 = no buffered lines and FSM is IDLE
// BEHAVIOUR
//  Reset: FIFO empty; all entries invalid; FSM IDLE; every output 0 except empty_o = 1.
//   Reset mid-drain: mem_enable_o drops asynchronously and buffered lines are discarded.
//  Storage: DEPTH entries of {valid, line_addr[ADDR_W-1:5], data}; circular FIFO with head, tail and count.
//  Request is "new" when cache_enable_i = 1 and cache_ack_o was 0 in the previous cycle.
//   The cycle after an ack never starts a new request.
//  Write-back, new request:
//   - Line matches a valid non-head entry, or the head entry while FSM != DRAIN: overwrite data in place (coalesce).
//   - Otherwise, if count < DEPTH: push at tail.
//   - Either case: cache_ack_o pulses on the next edge (latency 1).
//   - FIFO full and no coalesce possible: request waits; it is accepted in the cycle after a drain pops.
//  Fill, new request:
//   - Line matches a valid entry: forward the youngest match; ack latency 1; no memory access.
//   - Otherwise: fetch from memory. cache_data_o = mem_data_i registered; cache_ack_o pulses the cycle after mem_ack_i.
//  FSM:
//   IDLE  -> READ   : pending fill misses the buffer (fill has priority over drain).
//   IDLE  -> DRAIN  : otherwise, if count > 0. Head addr and data are latched to mem_* outputs.
//   READ  -> ACK    : on mem_ack_i.
//   DRAIN -> IDLE   : on mem_ack_i; head is popped in the same edge.
//   ACK   -> IDLE   : unconditionally, after one cycle.
//   mem_enable_o = 1 in READ and DRAIN only; mem_write_o = 1 in DRAIN only.
//  Simultaneous push and pop in one edge: count unchanged; this is legal when full (the pop frees the slot first).
//  A fill that misses while DRAIN is active waits; it enters READ once DRAIN returns to IDLE.
//  Ordering: one memory request is outstanding at a time; drains leave in FIFO order.
//   A fill never bypasses a buffered write to the same line, because such a fill is forwarded.
//  Head/tail pointers wrap modulo DEPTH; count saturates at DEPTH and never wraps.
// TESTING  (memory model acks 10 cycles after enable)
//  Write-back 0x0400, data A, buffer empty -> ack at +1; empty_o = 0.
//   Then mem_write_o = 1 to 0x0400 with data A; empty_o = 1 after mem ack.
//  Write-back 0x0200 = A, then fill 0x0200 before the drain completes -> ack at +1.
//   cache_data_o = A; no mem read issued.
//  Fill 0x0040 with buffer empty -> mem read to 0x0040; ack 1 cycle after mem_ack_i.
//   cache_data_o = memory[2].
//  DEPTH = 2; write-backs 0x000, 0x020, 0x040 back to back:
//   - third write's ack is withheld until the drain of 0x000 pops;
//   - memory then sees writes to 0x000, 0x020, 0x040 in that order.
//  Write-back 0x020 = B, then 0x020 = C while 0x000 is head and draining -> coalesce.
//   Memory receives 0x020 = C only once.
//  Assert rst_i mid-DRAIN -> mem_enable_o = 0 the same cycle; empty_o = 1; no further mem requests.

Source files
------------

// File: rtl/dcache_write_buffer.sv
// Line-granular posted write buffer between the L1 data cache and data memory.
// Write-backs are acked in one cycle and drained in FIFO order in the background.
// Fills are forwarded from buffered lines when possible, otherwise fetched from memory.
module dcache_write_buffer #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cache_addr_i,
  input  logic [LINE_W-1:0] cache_data_i,
  input  logic              cache_enable_i,
  input  logic              cache_write_i,
  output logic              cache_ack_o,
  output logic [LINE_W-1:0] cache_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              empty_o
);

  localparam int unsigned OFF_W = 5;
  localparam int unsigned TAG_W = ADDR_W - OFF_W;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef logic [PTR_W-1:0] ptr_t;

  // FIFO storage
  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  ptr_t              head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  state_t            state_q, state_d;
  logic              ack_prev_q;

  // Next-state / datapath control
  ptr_t              head_d, tail_d;
  logic [CNT_W-1:0]  count_d;
  logic              req_c;
  logic [TAG_W-1:0]  req_tag_c;
  logic              co_hit_c, fwd_hit_c;
  ptr_t              co_idx_c, fwd_idx_c, slot_c;
  logic              wr_c, push_c, pop_c, fill_miss_c;
  ptr_t              wr_idx_c;
  logic              ack_d;
  logic [LINE_W-1:0] cache_data_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [LINE_W-1:0] mem_data_d;

  // Byte offset within a line is irrelevant: a whole line is the unit of transfer.
  logic unused_offset_bits;
  assign unused_offset_bits = ^cache_addr_i[OFF_W-1:0];

  // A request is only acted on while no ack is showing and not in the cycle after one.
  assign req_c     = cache_enable_i & ~cache_ack_o & ~ack_prev_q;
  assign req_tag_c = cache_addr_i[ADDR_W-1:OFF_W];

  // Search live entries oldest to youngest; the last match found is the youngest.
  always_comb begin : match_search
    co_hit_c  = 1'b0;
    co_idx_c  = '0;
    fwd_hit_c = 1'b0;
    fwd_idx_c = '0;
    slot_c    = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_c = head_q + PTR_W'(i);
      if (valid_q[slot_c] && (tag_q[slot_c] == req_tag_c)) begin
        fwd_hit_c = 1'b1;
        fwd_idx_c = slot_c;
        // The head is frozen once its drain has been launched.
        if ((i != 0) || (state_q != DRAIN)) begin
          co_hit_c = 1'b1;
          co_idx_c = slot_c;
        end
      end
    end
  end

  // Next-state, FIFO bookkeeping and next values of registered outputs.
  always_comb begin : next_state
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    wr_c         = 1'b0;
    wr_idx_c     = tail_q;
    push_c       = 1'b0;
    fill_miss_c  = 1'b0;
    ack_d        = 1'b0;
    cache_data_d = '0;
    mem_addr_d   = mem_addr_o;
    mem_data_d   = mem_data_o;
    pop_c        = (state_q == DRAIN) && mem_ack_i;

    // Write-back: coalesce into a matching entry, else push if a slot is (or is being) freed.
    if (req_c && cache_write_i) begin
      if (co_hit_c) begin
        wr_c     = 1'b1;
        wr_idx_c = co_idx_c;
        ack_d    = 1'b1;
      end else if ((count_q != CNT_W'(DEPTH)) || pop_c) begin
        wr_c   = 1'b1;
        push_c = 1'b1;
        ack_d  = 1'b1;
      end
    end

    // Fill: forward from the buffer or flag a miss for the FSM.
    if (req_c && !cache_write_i && ((state_q == IDLE) || (state_q == DRAIN))) begin
      if (fwd_hit_c) begin
        ack_d        = 1'b1;
        cache_data_d = data_q[fwd_idx_c];
      end else begin
        fill_miss_c = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (fill_miss_c) begin
          state_d    = READ;
          mem_addr_d = {req_tag_c, OFF_W'(0)};
        end else if (count_q != '0) begin
          state_d    = DRAIN;
          mem_addr_d = {tag_q[head_q], OFF_W'(0)};
          // A coalesce into the head on this same edge must reach memory.
          mem_data_d = (wr_c && (wr_idx_c == head_q)) ? cache_data_i : data_q[head_q];
        end
      end
      READ: begin
        if (mem_ack_i) begin
          state_d      = ACK;
          ack_d        = 1'b1;
          cache_data_d = mem_data_i;
        end
      end
      DRAIN: begin
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push_c) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop_c) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // State, pointers, valid bits and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      ack_prev_q   <= 1'b0;
      cache_ack_o  <= 1'b0;
      cache_data_o <= '0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      empty_o      <= 1'b1;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      ack_prev_q   <= cache_ack_o;
      cache_ack_o  <= ack_d;
      cache_data_o <= cache_data_d;
      mem_addr_o   <= mem_addr_d;
      mem_data_o   <= mem_data_d;
      mem_enable_o <= (state_d == READ) || (state_d == DRAIN);
      mem_write_o  <= (state_d == DRAIN);
      empty_o      <= (count_d == '0) && (state_d == IDLE);
      // Pop clears first so a push into the slot freed on the same edge wins.
      if (pop_c) begin
        valid_q[head_q] <= 1'b0;
      end
      if (push_c) begin
        valid_q[tail_q] <= 1'b1;
      end
    end
  end

  // Line storage; contents are qualified by valid_q and need no reset.
  always_ff @(posedge clk_i) begin
    if (wr_c) begin
      data_q[wr_idx_c] <= cache_data_i;
      tag_q[wr_idx_c]  <= req_tag_c;
    end
  end

endmodule
